// File: rtl/bit_serial_pkg.sv
// Shared types and constants for the bit-serial arithmetic cells.
// The full-adder truth tables are indexed by {a,b,c}.
package bit_serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [7:0] FA_SUM_TT   = 8'b10010110;
  localparam logic [7:0] FA_CARRY_TT = 8'b11101000;

endpackage

// File: rtl/bit_serial_full_adder_if.sv
// Request/result bundle of the bit-serial adder.
// Optional macro SERIAL_ADD_OVF_EN adds the signed-overflow flag ovf.
interface bit_serial_full_adder_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;

  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/Mux_8_1.sv
// Generic 8:1 single-bit multiplexer.
module Mux_8_1 (
  input  logic [7:0] d,
  input  logic [2:0] sel,
  output logic       y
);

  assign y = d[sel];

endmodule

// File: rtl/bit_serial_full_adder_fa_mux8_cell.sv
// One-bit full adder built from two 8:1 muxes driven by constant truth tables.
module fa_mux8_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  import bit_serial_pkg::*;

  logic [2:0] sel;

  assign sel = {a, b, c};

  Mux_8_1 u_sum_mux (
    .d   (FA_SUM_TT),
    .sel (sel),
    .y   (s)
  );

  Mux_8_1 u_carry_mux (
    .d   (FA_CARRY_TT),
    .sel (sel),
    .y   (co)
  );

endmodule

// File: rtl/bit_serial_full_adder.sv
// Bit-serial WIDTH-bit adder: LSB-first through one mux-built full-adder cell.
// Optional macro SERIAL_ADD_OVF_EN adds the registered signed-overflow output.
module bit_serial_full_adder #(
  parameter int WIDTH = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  bit_serial_full_adder_if.slave bus
);

  import bit_serial_pkg::*;

  localparam int              CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             s;
  logic             c_next;
  logic             accept;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q;
`endif

  fa_mux8_cell u_cell (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .c  (carry),
    .s  (s),
    .co (c_next)
  );

  // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  always_comb begin
    sum_nxt = '0;
    sum_nxt[WIDTH-1] = s;
    for (int unsigned i = 0; i + 1 < WIDTH; i++) begin
      sum_nxt[i] = sum_sr[i+1];
    end
  end

  assign accept = bus.start && (state == IDLE || state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        a_sr   <= bus.a;
        b_sr   <= bus.b;
        carry  <= bus.cin;
        sum_sr <= '0;
        cnt    <= '0;
        busy_q <= 1'b1;
        state  <= RUN;
      end else begin
        case (state)
          RUN: begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            carry  <= c_next;
            sum_sr <= sum_nxt;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) begin
              // Result registers load from the final-step values, not the shift regs.
              sum_q  <= sum_nxt;
              cout_q <= c_next;
`ifdef SERIAL_ADD_OVF_EN
              ovf_q  <= carry ^ c_next;
`endif
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_bit_serial_full_adder.sv
// Randomized self-checking bench for bit_serial_full_adder (WIDTH=8 and WIDTH=1).
module tb_bit_serial_full_adder;

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  logic [7:0] model8_sum;
  logic       model8_cout;
  logic       model8_ovf;
  logic       model1_sum;
  logic       model1_cout;

  bit_serial_full_adder_if #(.WIDTH(8)) bus8 ();
  bit_serial_full_adder_if #(.WIDTH(1)) bus1 ();

  bit_serial_full_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  bit_serial_full_adder #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ovf_of(input logic [7:0] a, input logic [7:0] b, input logic [7:0] s);
    return (a[7] == b[7]) && (s[7] != a[7]);
  endfunction

  task automatic clear_models();
    model8_sum  = '0;
    model8_cout = 1'b0;
    model8_ovf  = 1'b0;
    model1_sum  = 1'b0;
    model1_cout = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus8.busy, bus8.done, bus8.sum, bus8.cout} !== 11'h0) begin
      errors++;
      $display("FAIL reset8: got busy=%b done=%b sum=%h cout=%b, expected all zero",
               bus8.busy, bus8.done, bus8.sum, bus8.cout);
    end
    checks++;
    if ({bus1.busy, bus1.done, bus1.sum, bus1.cout} !== 4'h0) begin
      errors++;
      $display("FAIL reset1: got busy=%b done=%b sum=%b cout=%b, expected all zero",
               bus1.busy, bus1.done, bus1.sum, bus1.cout);
    end
`ifdef SERIAL_ADD_OVF_EN
    checks++;
    if (bus8.ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: got %b expected 0", bus8.ovf);
    end
`endif
    clear_models();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One WIDTH=8 addition; optionally raises a competing start mid-RUN.
  task automatic do_add8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input bit inject);
    logic [8:0] exp;
    int n;
    exp = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    bus8.start = 1'b1;
    bus8.a     = a;
    bus8.b     = b;
    bus8.cin   = cin;
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.a     = 8'($urandom);
    bus8.b     = 8'($urandom);
    bus8.cin   = 1'($urandom);
    n = 1;
    while (bus8.done !== 1'b1 && n < 20) begin
      checks++;
      if (bus8.busy !== 1'b1) begin
        errors++;
        $display("FAIL run_busy: cycle %0d got %b expected 1", n, bus8.busy);
      end
      checks++;
      if ({bus8.cout, bus8.sum} !== {model8_cout, model8_sum}) begin
        errors++;
        $display("FAIL hold_result: cycle %0d got %h expected %h", n,
                 {bus8.cout, bus8.sum}, {model8_cout, model8_sum});
      end
      if (inject && n == 3) bus8.start = 1'b1;
      if (inject && n == 4) bus8.start = 1'b0;
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 9) begin
      errors++;
      $display("FAIL latency8: got %0d cycles expected 9", n);
    end
    checks++;
    if ({bus8.cout, bus8.sum} !== exp) begin
      errors++;
      $display("FAIL sum8: %h+%h+%b got %h expected %h", a, b, cin, {bus8.cout, bus8.sum}, exp);
    end
    checks++;
    if (bus8.busy !== 1'b0) begin
      errors++;
      $display("FAIL done_busy: got %b expected 0", bus8.busy);
    end
    model8_sum  = exp[7:0];
    model8_cout = exp[8];
    model8_ovf  = ovf_of(a, b, exp[7:0]);
`ifdef SERIAL_ADD_OVF_EN
    checks++;
    if (bus8.ovf !== model8_ovf) begin
      errors++;
      $display("FAIL ovf8: %h+%h+%b got %b expected %b", a, b, cin, bus8.ovf, model8_ovf);
    end
`endif
    @(negedge clk);
    checks++;
    if (bus8.done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: got %b expected 0", bus8.done);
    end
  endtask

  task automatic test_basic();
    do_add8(8'h0F, 8'h01, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    do_add8(8'hFF, 8'h01, 1'b0, 1'b0);
    do_add8(8'h00, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      do_add8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    end
  endtask

  task automatic test_ignore_start();
    do_add8(8'h3C, 8'h5A, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) begin
        errors++;
        $display("FAIL ignored_start: cycle %0d got busy=%b done=%b expected 0/0",
                 i, bus8.busy, bus8.done);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int last;
    int pulses;
    bus8.start = 1'b1;
    bus8.a     = 8'h55;
    bus8.b     = 8'hAA;
    bus8.cin   = 1'b1;
    n = 0;
    last = 0;
    pulses = 0;
    while (pulses < 3 && n < 60) begin
      @(negedge clk);
      n++;
      if (bus8.done === 1'b1) begin
        pulses++;
        checks++;
        if (n - last != 9) begin
          errors++;
          $display("FAIL b2b_interval: pulse %0d got %0d expected 9", pulses, n - last);
        end
        checks++;
        if ({bus8.cout, bus8.sum} !== 9'h100) begin
          errors++;
          $display("FAIL b2b_sum: pulse %0d got %h expected 100", pulses, {bus8.cout, bus8.sum});
        end
        last = n;
      end
    end
    bus8.start = 1'b0;
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d pulses expected 3", pulses);
    end
    model8_sum  = 8'h00;
    model8_cout = 1'b1;
    model8_ovf  = 1'b0;
    @(negedge clk);
    checks++;
    if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop: got busy=%b done=%b expected 0/0", bus8.busy, bus8.done);
    end
  endtask

  task automatic test_reset_mid_run();
    bus8.start = 1'b1;
    bus8.a     = 8'hC3;
    bus8.b     = 8'h7E;
    bus8.cin   = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus8.busy, bus8.done, bus8.sum, bus8.cout} !== 11'h0) begin
      errors++;
      $display("FAIL midrun_reset: got busy=%b done=%b sum=%h cout=%b expected all zero",
               bus8.busy, bus8.done, bus8.sum, bus8.cout);
    end
    clear_models();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (bus8.done !== 1'b0) begin
        errors++;
        $display("FAIL midrun_no_done: cycle %0d got %b expected 0", i, bus8.done);
      end
    end
    do_add8(8'h12, 8'h34, 1'b0, 1'b0);
  endtask

  task automatic do_add1(input logic a, input logic b, input logic cin);
    logic [1:0] exp;
    int n;
    exp = 2'(a) + 2'(b) + 2'(cin);
    bus1.start = 1'b1;
    bus1.a     = a;
    bus1.b     = b;
    bus1.cin   = cin;
    @(negedge clk);
    bus1.start = 1'b0;
    n = 1;
    while (bus1.done !== 1'b1 && n < 10) begin
      checks++;
      if (bus1.busy !== 1'b1 || {bus1.cout, bus1.sum} !== {model1_cout, model1_sum}) begin
        errors++;
        $display("FAIL run1: cycle %0d got busy=%b result=%b expected busy=1 result=%b",
                 n, bus1.busy, {bus1.cout, bus1.sum}, {model1_cout, model1_sum});
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL latency1: got %0d cycles expected 2", n);
    end
    checks++;
    if ({bus1.cout, bus1.sum} !== exp) begin
      errors++;
      $display("FAIL sum1: %b+%b+%b got %b expected %b", a, b, cin, {bus1.cout, bus1.sum}, exp);
    end
    model1_sum  = exp[0];
    model1_cout = exp[1];
    @(negedge clk);
  endtask

  task automatic test_width1();
    logic [2:0] v;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      do_add1(v[2], v[1], v[0]);
    end
  endtask

`ifdef SERIAL_ADD_OVF_EN
  task automatic test_ovf();
    do_add8(8'h7F, 8'h01, 1'b0, 1'b0);
    checks++;
    if (bus8.ovf !== 1'b1 || bus8.sum !== 8'h80) begin
      errors++;
      $display("FAIL ovf_pos: got ovf=%b sum=%h expected 1/80", bus8.ovf, bus8.sum);
    end
    do_add8(8'hFF, 8'h01, 1'b0, 1'b0);
    checks++;
    if (bus8.ovf !== 1'b0 || bus8.cout !== 1'b1) begin
      errors++;
      $display("FAIL ovf_neg: got ovf=%b cout=%b expected 0/1", bus8.ovf, bus8.cout);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    bus8.start = 1'b0;
    bus8.a     = '0;
    bus8.b     = '0;
    bus8.cin   = 1'b0;
    bus1.start = 1'b0;
    bus1.a     = '0;
    bus1.b     = '0;
    bus1.cin   = 1'b0;
    clear_models();
    @(negedge clk);
    test_reset();
    test_basic();
    test_wrap();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_width1();
`ifdef SERIAL_ADD_OVF_EN
    test_ovf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
